// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package div_pkg;

    localparam int DIV_DEFAULT_WIDTH = 16;

    typedef logic [1:0] div_state_t;

    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_CALC = 2'd1;
    localparam div_state_t ST_FIX  = 2'd2;
    localparam div_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/div_addsub.sv
// Carry-propagate adder/subtractor shared by the divide iterations and the final
// remainder correction. sub_i=1 computes a_i - b_i.
module div_addsub #(
    parameter int W = 17
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W-1:0] b_x;

    assign b_x = b_i ^ {W{sub_i}};
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_x} + {{W{1'b0}}, sub_i};

endmodule

// File: rtl/seq_divider.sv
// Sequential non-restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's-complement operands and results.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dv_q, dv_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
`endif

    logic [WIDTH:0]   add_a, add_b, add_sum;
    logic             add_sub;
    logic             add_cout_unused;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH-1:0] rem_fix;

    // Iteration: shift {P,Q} left, then subtract D if P was non-negative, else add.
    // FIX reuses the same adder to add D back to a negative remainder.
    assign p_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign add_a   = (state_q == ST_FIX) ? p_q : p_shift;
    assign add_b   = {1'b0, dv_q};
    assign add_sub = (state_q == ST_FIX) ? 1'b0 : ~p_q[WIDTH];
    assign rem_fix = p_q[WIDTH] ? add_sum[WIDTH-1:0] : p_q[WIDTH-1:0];

    div_addsub #(.W(WIDTH + 1)) u_addsub (
        .a_i    (add_a),
        .b_i    (add_b),
        .sub_i  (add_sub),
        .sum_o  (add_sum),
        .cout_o (add_cout_unused)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        dv_d    = dv_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    q_d   = dividend;
                    dv_d  = divisor;
                    p_d   = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                // Count 0 is a setup cycle; counts 1..WIDTH each retire one quotient bit.
                if (cnt_q == '0) begin
                    p_d = '0;
`ifdef DIV_SIGNED_EN
                    negq_d = q_q[WIDTH-1] ^ dv_q[WIDTH-1];
                    negr_d = q_q[WIDTH-1];
                    q_d    = q_q[WIDTH-1] ? -q_q : q_q;
                    dv_d   = dv_q[WIDTH-1] ? -dv_q : dv_q;
`endif
                end else begin
                    p_d = add_sum;
                    q_d = {q_q[WIDTH-2:0], ~add_sum[WIDTH]};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIX: begin
`ifdef DIV_SIGNED_EN
                quo_d = negq_q ? -q_q : q_q;
                rem_d = negr_q ? -rem_fix : rem_fix;
`else
                quo_d = q_q;
                rem_d = rem_fix;
`endif
                dbz_d   = 1'b0;
                state_d = ST_DONE;
            end
            default: begin
                if (out_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            dv_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dv_q    <= dv_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider (WIDTH=16) against an arithmetic model.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; divide-by-zero returns all-ones / dividend.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic z);
`ifdef DIV_SIGNED_EN
        int sa;
        int sb;
`endif
        if (b == 16'h0) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
`else
            q  = a / b;
            r  = a % b;
`endif
            z = 1'b0;
        end
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [15:0] eq;
        logic [15:0] er;
        logic        ez;
        int          k;
        model(a, b, eq, er, ez);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 100) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk("latency", 32'(k), (b == 16'h0) ? 32'd0 : 32'd18);
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), 32'(ez));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_quo", 32'(quotient), 32'(eq));
            chk("hold_rem", 32'(remainder), 32'(er));
            chk("hold_dbz", 32'(div_by_zero), 32'(ez));
        end
        // Offer a new op on the consuming edge; it must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("consumed_valid", 32'(out_valid), 32'd0);
        chk("consumed_ready", 32'(in_ready), 32'd1);
        chk("retain_quo", 32'(quotient), 32'(eq));
        chk("retain_rem", 32'(remainder), 32'(er));
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          sel;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 16'h0;
        divisor   = 16'h0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quo", 32'(quotient), 32'd0);
        chk("rst_rem", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'd100, 16'd7, 5);
        run_op(16'hFFFF, 16'h0001, 0);
        run_op(16'h0003, 16'h0010, 0);
        run_op(16'd5, 16'd0, 2);
        run_op(16'd9, 16'd3, 0);
`ifdef DIV_SIGNED_EN
        run_op(16'hFFF9, 16'h0002, 0);
        run_op(16'h8000, 16'hFFFF, 0);
        run_op(16'h8000, 16'h0001, 0);
        run_op(16'h0007, 16'hFFFE, 0);
`endif

        // Abort an operation mid-calculation with an asynchronous reset.
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_quo", 32'(quotient), 32'd0);
        chk("abort_rem", 32'(remainder), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            chk("abandoned", 32'(out_valid), 32'd0);
        end
        run_op(16'd9, 16'd3, 0);

        for (int i = 0; i < 60; i++) begin
            ra  = 16'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0)      rb = 16'h0;
            else if (sel < 3)  rb = 16'($urandom_range(1, 15));
            else               rb = 16'($urandom);
            run_op(ra, rb, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
